// File: rtl/osc_mon_pkg.sv
// Shared types and defaults for the oscillation-flag monitor.
package osc_mon_pkg;

  localparam int WIN_LEN_DEF = 64;
  localparam int THRESH_DEF  = 4;
  localparam int VEC_W_DEF   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_MON   = 2'b01,
    S_ALARM = 2'b10
  } osc_state_e;

  // Plain-vector aliases of the enum so state_o can be driven without casts.
  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_MON   = S_MON;
  localparam logic [1:0] ST_ALARM = S_ALARM;

endpackage

// File: rtl/osc_sync_edge.sv
// Three-flop synchroniser for the asynchronous OscFlag plus an XOR edge
// detector on the two settled stages.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic edge_pulse
);

  logic ff1;
  logic ff2;
  logic ff3;

  // NOTE: flops use non-blocking (<=) so every stage samples the previous
  // stage's old value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
      ff3 <= 1'b0;
    end else begin
      ff1 <= d_async;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign edge_pulse = ff2 ^ ff3;

endmodule

// File: rtl/osc_flag_monitor.sv
// Counts synchronised OscFlag toggles per fixed window, raises a sticky alarm at
// the threshold and captures the loop stimulus vector on alarm entry.
module osc_flag_monitor
  import osc_mon_pkg::*;
#(
  parameter  int WIN_LEN = WIN_LEN_DEF,
  parameter  int THRESH  = THRESH_DEF,
  parameter  int VEC_W   = VEC_W_DEF,
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             osc_flag_async,
  input  logic [VEC_W-1:0] stim_vec,
  output logic             alarm,
  output logic [VEC_W-1:0] alarm_vec,
  output logic [CNT_W-1:0] win_toggles,
  output logic             win_done,
  output logic [1:0]       state_o
);

  if (THRESH < 1 || THRESH > WIN_LEN || WIN_LEN < 2) begin : g_bad_params
    $error("osc_flag_monitor: need WIN_LEN>=2 and 1<=THRESH<=WIN_LEN");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] tog_cnt;
  logic [CNT_W-1:0] tog_next;
  logic             edge_pulse;
  logic             win_end;
  logic             thresh_hit;

  osc_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_async    (osc_flag_async),
    .edge_pulse (edge_pulse)
  );

  // NOTE: tog_next gets its default before the conditional update, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    tog_next = tog_cnt;
    if (edge_pulse && (tog_cnt != CNT_W'(WIN_LEN))) begin
      tog_next = tog_cnt + CNT_W'(1);
    end
  end

  assign win_end    = (win_cnt == CNT_W'(WIN_LEN - 1));
  assign thresh_hit = (tog_next >= CNT_W'(THRESH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      win_cnt     <= '0;
      tog_cnt     <= '0;
      win_toggles <= '0;
      win_done    <= 1'b0;
      alarm       <= 1'b0;
      alarm_vec   <= '0;
    end else begin
      win_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          win_cnt <= '0;
          tog_cnt <= '0;
          if (en) state <= ST_MON;
        end
        ST_MON: begin
          if (clr) begin
            win_cnt <= '0;
            tog_cnt <= '0;
          end else if (!en) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
            tog_cnt <= '0;
          end else begin
            // Window end and threshold are independent: both may fire at once.
            if (win_end) begin
              win_done    <= 1'b1;
              win_toggles <= tog_next;
              win_cnt     <= '0;
              tog_cnt     <= '0;
            end else begin
              win_cnt <= win_cnt + CNT_W'(1);
              tog_cnt <= tog_next;
            end
            if (thresh_hit) begin
              state     <= ST_ALARM;
              alarm     <= 1'b1;
              alarm_vec <= stim_vec;
            end
          end
        end
        ST_ALARM: begin
          // Counters stay frozen; only clr leaves this state.
          if (clr) begin
            state <= ST_IDLE;
            alarm <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_osc_flag_monitor.sv
// Directed bench for osc_flag_monitor: reset, window counting, alarm entry,
// alarm hold/clear, alarm on the window-end cycle and clr restart.
module tb_osc_flag_monitor;

  localparam int WIN_LEN = 64;
  localparam int THRESH  = 4;
  localparam int VEC_W   = 8;
  localparam int CNT_W   = $clog2(WIN_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             osc_flag_async;
  logic [VEC_W-1:0] stim_vec;
  logic             alarm;
  logic [VEC_W-1:0] alarm_vec;
  logic [CNT_W-1:0] win_toggles;
  logic             win_done;
  logic [1:0]       state_o;

  int tests = 0;
  int fails = 0;
  int n     = 0;

  osc_flag_monitor #(.WIN_LEN(WIN_LEN), .THRESH(THRESH), .VEC_W(VEC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .clr            (clr),
    .osc_flag_async (osc_flag_async),
    .stim_vec       (stim_vec),
    .alarm          (alarm),
    .alarm_vec      (alarm_vec),
    .win_toggles    (win_toggles),
    .win_done       (win_done),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic flip();
    osc_flag_async = ~osc_flag_async;
  endtask

  task automatic test_reset();
    en    = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    stim_vec = 8'hFF;
    repeat (3) begin flip(); tick(); end
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL reset_state got=%b exp=00", state_o); end
    tests++; if (alarm !== 1'b0) begin fails++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    tests++; if (alarm_vec !== 8'h00) begin fails++; $display("FAIL reset_alarm_vec got=%h exp=00", alarm_vec); end
    tests++; if (win_toggles !== 7'd0) begin fails++; $display("FAIL reset_win_toggles got=%0d exp=0", win_toggles); end
    tests++; if (win_done !== 1'b0) begin fails++; $display("FAIL reset_win_done got=%b exp=0", win_done); end
    rst_n = 1'b1;
    repeat (4) tick();
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL post_reset_idle got=%b exp=00", state_o); end
  endtask

  task automatic test_window_count();
    logic early;
    early = 1'b0;
    en = 1'b1;
    tick();
    n = 0;
    tests++; if (state_o !== 2'b01) begin fails++; $display("FAIL win_enter_mon got=%b exp=01", state_o); end
    for (int i = 0; i < 64; i++) begin
      if (win_done !== 1'b0) early = 1'b1;
      if (i == 0 || i == 10 || i == 20) flip();
      tick();
    end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL win_early_done got=1 exp=0"); end
    tests++; if (win_done !== 1'b1) begin fails++; $display("FAIL win_done_pulse got=%b exp=1", win_done); end
    tests++; if (win_toggles !== 7'd3) begin fails++; $display("FAIL win_toggles3 got=%0d exp=3", win_toggles); end
    tests++; if (alarm !== 1'b0) begin fails++; $display("FAIL win_no_alarm got=%b exp=0", alarm); end
    tick();
    tests++; if (win_done !== 1'b0) begin fails++; $display("FAIL win_done_width got=%b exp=0", win_done); end
    repeat (63) tick();
    tests++; if (win_done !== 1'b1 || win_toggles !== 7'd0) begin
      fails++; $display("FAIL win_second got done=%b tog=%0d exp done=1 tog=0", win_done, win_toggles);
    end
  endtask

  task automatic test_alarm_entry();
    en = 1'b0;
    tick();
    en = 1'b1;
    stim_vec = 8'h5A;
    tick();
    n = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 0 || i == 2 || i == 4 || i == 8) flip();
      if (i == 10) begin
        tests++; if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_too_early got=%b exp=0", alarm); end
        stim_vec = 8'hA5;
      end
      tick();
    end
    stim_vec = 8'h3C;
    tests++; if (alarm !== 1'b1) begin fails++; $display("FAIL alarm_entry got=%b exp=1", alarm); end
    tests++; if (alarm_vec !== 8'hA5) begin fails++; $display("FAIL alarm_vec_cap got=%h exp=a5", alarm_vec); end
    tests++; if (state_o !== 2'b10) begin fails++; $display("FAIL alarm_state got=%b exp=10", state_o); end
  endtask

  task automatic test_alarm_hold_clear();
    repeat (10) begin flip(); tick(); end
    en = 1'b0;
    repeat (4) tick();
    tests++; if (alarm !== 1'b1 || state_o !== 2'b10) begin
      fails++; $display("FAIL alarm_sticky got alarm=%b state=%b exp 1/10", alarm, state_o);
    end
    tests++; if (alarm_vec !== 8'hA5) begin fails++; $display("FAIL alarm_vec_hold got=%h exp=a5", alarm_vec); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL clr_to_idle got=%b exp=00", state_o); end
    tests++; if (alarm !== 1'b0) begin fails++; $display("FAIL clr_alarm_low got=%b exp=0", alarm); end
    tests++; if (alarm_vec !== 8'hA5) begin fails++; $display("FAIL clr_vec_hold got=%h exp=a5", alarm_vec); end
    tick();
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL idle_en_low got=%b exp=00", state_o); end
  endtask

  task automatic test_alarm_at_window_end();
    stim_vec = 8'hC3;
    en = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10 || i == 20 || i == 30 || i == 61) flip();
      if (i == 63) begin
        tests++; if (alarm !== 1'b0) begin fails++; $display("FAIL wend_alarm_early got=%b exp=0", alarm); end
      end
      tick();
    end
    tests++; if (alarm !== 1'b1 || state_o !== 2'b10) begin
      fails++; $display("FAIL wend_alarm got alarm=%b state=%b exp 1/10", alarm, state_o);
    end
    tests++; if (win_done !== 1'b1) begin fails++; $display("FAIL wend_done got=%b exp=1", win_done); end
    tests++; if (win_toggles !== 7'd4) begin fails++; $display("FAIL wend_toggles got=%0d exp=4", win_toggles); end
    tests++; if (alarm_vec !== 8'hC3) begin fails++; $display("FAIL wend_vec got=%h exp=c3", alarm_vec); end
    tick();
    tests++; if (win_done !== 1'b0 || state_o !== 2'b10) begin
      fails++; $display("FAIL wend_after got done=%b state=%b exp 0/10", win_done, state_o);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_clr_restart();
    logic early;
    logic bad_alarm;
    early     = 1'b0;
    bad_alarm = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 85; i++) begin
      if (i >= 21 && win_done !== 1'b0) early = 1'b1;
      if (i >= 21 && alarm !== 1'b0) bad_alarm = 1'b1;
      if (i == 0 || i == 2 || i == 4 || i == 18 || i == 30 || i == 40 || i == 50) flip();
      if (i == 20) clr = 1'b1;
      if (i == 21) clr = 1'b0;
      tick();
    end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL clr_no_done got=1 exp=0"); end
    tests++; if (bad_alarm !== 1'b0) begin fails++; $display("FAIL clr_beats_thresh got=1 exp=0"); end
    tests++; if (win_done !== 1'b1) begin fails++; $display("FAIL clr_window_done got=%b exp=1", win_done); end
    tests++; if (win_toggles !== 7'd3) begin fails++; $display("FAIL clr_window_toggles got=%0d exp=3", win_toggles); end
    tests++; if (alarm !== 1'b0 || state_o !== 2'b01) begin
      fails++; $display("FAIL clr_final got alarm=%b state=%b exp 0/01", alarm, state_o);
    end
  endtask

  initial begin
    osc_flag_async = 1'b0;
    stim_vec       = '0;
    en             = 1'b0;
    clr            = 1'b0;
    rst_n          = 1'b0;
    #2;
    test_reset();
    test_window_count();
    test_alarm_entry();
    test_alarm_hold_clear();
    test_alarm_at_window_end();
    test_clr_restart();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
